// File: rtl/axi_sram_pkg.sv
// Shared AXI burst/response encodings and FSM state types for the burst SRAM slave.
// No logic; pure definitions.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Only power-of-two beat counts of 2..16 form a legal wrap window.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Per-beat address helper: word index, range check, burst legality and next beat address.
// Purely combinational; no state, no backpressure.
module axi_sram_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BYTES       = 8,
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_in_range,
    output logic              o_burst_err
);

    localparam int OFF = $clog2(BYTES);

    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_size;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_incr;
    logic              w_wrap_ok;

    assign w_word      = i_addr >> OFF;
    assign o_idx       = w_word[IDX_W-1:0];
    assign o_in_range  = (w_word < ADDR_W'(DEPTH_WORDS));

    assign w_wrap_ok   = (i_burst == BURST_WRAP) && wrap_len_ok(i_len);
    assign o_burst_err = !((i_burst == BURST_FIXED) || (i_burst == BURST_INCR) || w_wrap_ok);

    // Wrap window is (len+1) beats, aligned to its own size; arithmetic wraps at 2^ADDR_W.
    assign w_size = (ADDR_W'(i_len) + ADDR_W'(1)) << OFF;
    assign w_mask = w_size - ADDR_W'(1);
    assign w_incr = i_addr + ADDR_W'(BYTES);

    always_comb begin
        o_next_addr = w_incr;
        if (i_burst == BURST_FIXED) begin
            o_next_addr = i_addr;
        end else if (w_wrap_ok) begin
            o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
        end
    end

endmodule

// File: rtl/axi_burst_sram.sv
// AXI4 burst slave over a byte-writable SRAM; independent read and write channels.
// First rvalid RD_LAT cycles after AR; one beat per handshake, outputs held while stalled.
module axi_burst_sram
    import axi_sram_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    rd_state_t         r_rstate;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen;
    logic [1:0]        r_rburst;
    logic [7:0]        r_rbeat;
    logic [3:0]        r_rwait;

    logic [ADDR_W-1:0] w_rsel_addr;
    logic [7:0]        w_rsel_len;
    logic [1:0]        w_rsel_burst;
    logic [ADDR_W-1:0] w_rd_next;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_in_range;
    logic              w_rd_err;
    logic [DATA_W-1:0] w_rd_word;
    logic [1:0]        w_rd_resp;
    logic              w_ar_hs;
    logic              w_r_hs;

    // r_raddr always points at the next beat to fetch; in idle the fetch address is araddr itself.
    assign w_rsel_addr  = (r_rstate == R_IDLE) ? araddr  : r_raddr;
    assign w_rsel_len   = (r_rstate == R_IDLE) ? arlen   : r_rlen;
    assign w_rsel_burst = (r_rstate == R_IDLE) ? arburst : r_rburst;

    axi_sram_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BYTES       (BYTES),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_rd_gen (
        .i_addr      (w_rsel_addr),
        .i_len       (w_rsel_len),
        .i_burst     (w_rsel_burst),
        .o_next_addr (w_rd_next),
        .o_idx       (w_rd_idx),
        .o_in_range  (w_rd_in_range),
        .o_burst_err (w_rd_err)
    );

    assign w_rd_word = w_rd_in_range ? r_mem[w_rd_idx] : '0;
    assign w_rd_resp = (w_rd_in_range && !w_rd_err) ? RESP_OKAY : RESP_SLVERR;
    assign w_ar_hs   = arvalid && r_arready;
    assign w_r_hs    = r_rvalid && rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rburst  <= BURST_FIXED;
            r_rbeat   <= '0;
            r_rwait   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_rlen    <= arlen;
                        r_rburst  <= arburst;
                        r_rbeat   <= '0;
                        if (RD_LAT == 1) begin
                            r_rdata  <= w_rd_word;
                            r_rresp  <= w_rd_resp;
                            r_rlast  <= (arlen == 8'd0);
                            r_rvalid <= 1'b1;
                            r_raddr  <= w_rd_next;
                            r_rstate <= R_DATA;
                        end else begin
                            r_raddr  <= araddr;
                            r_rwait  <= 4'(RD_LAT - 1);
                            r_rstate <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_rwait == 4'd1) begin
                        r_rdata  <= w_rd_word;
                        r_rresp  <= w_rd_resp;
                        r_rlast  <= (r_rlen == 8'd0);
                        r_rvalid <= 1'b1;
                        r_raddr  <= w_rd_next;
                        r_rstate <= R_DATA;
                    end else begin
                        r_rwait <= r_rwait - 4'd1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= w_rd_word;
                            r_rresp <= w_rd_resp;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                            r_rbeat <= r_rbeat + 8'd1;
                            r_raddr <= w_rd_next;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // ---------------- write channel ----------------
    wr_state_t         r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [1:0]        r_wburst;
    logic [8:0]        r_wbeat;
    logic              r_werr;

    logic [ADDR_W-1:0] w_wr_next;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_in_range;
    logic              w_wr_err;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_w_inlen;
    logic              w_we;
    logic              w_beat_err;

    axi_sram_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BYTES       (BYTES),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_wr_gen (
        .i_addr      (r_waddr),
        .i_len       (r_wlen),
        .i_burst     (r_wburst),
        .o_next_addr (w_wr_next),
        .o_idx       (w_wr_idx),
        .o_in_range  (w_wr_in_range),
        .o_burst_err (w_wr_err)
    );

    assign w_aw_hs    = awvalid && r_awready;
    assign w_w_hs     = wvalid && r_wready;
    assign w_w_inlen  = (r_wbeat <= {1'b0, r_wlen});
    assign w_we       = w_w_hs && w_w_inlen && w_wr_in_range;
    assign w_beat_err = w_w_inlen && (!w_wr_in_range || w_wr_err);

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wburst  <= BURST_FIXED;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= awid;
                        r_waddr   <= awaddr;
                        r_wlen    <= awlen;
                        r_wburst  <= awburst;
                        r_wbeat   <= '0;
                        r_werr    <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_beat_err || (r_wbeat != {1'b0, r_wlen}))
                                        ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_werr  <= r_werr || w_beat_err;
                            r_waddr <= w_wr_next;
                            // Saturates past 255 so an overlong burst can never alias back to awlen.
                            if (r_wbeat != 9'h100) begin
                                r_wbeat <= r_wbeat + 9'd1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_burst_sram.sv
// Directed bench for axi_burst_sram: expected read beats are queued before each read and checked as they arrive.
module tb_axi_burst_sram;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_burst_sram dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    rexp_t       sb[$];
    logic [63:0] wdq[$];
    logic [63:0] rnd[8];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.d = d;
        e.resp = resp;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int nbeats, input logic [7:0] strb,
                            input logic [1:0] exp_resp);
        int cnt;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin step(); cnt++; end
        check("aw_ready", awready, 1'b1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wdq[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
            cnt = 0;
            while (!wready && cnt < 50) begin step(); cnt++; end
            check("w_ready", wready, 1'b1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 50) begin step(); cnt++; end
        check("b_valid", bvalid, 1'b1);
        check("bresp", bresp, exp_resp);
        check("bid", bid, id);
        step();
        bready = 1'b0;
        check("b_drop", bvalid, 1'b0);
        check("awready_back", awready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input bit toggle);
        int          cnt;
        bit          rr;
        rexp_t       e;
        logic [66:0] hold;
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < 50) begin step(); cnt++; end
        check("ar_ready", arready, 1'b1);
        step();
        arvalid = 1'b0;
        check("rd_latency", rvalid, 1'b1);
        rr = 1'b1;
        cnt = 0;
        while (sb.size() > 0 && cnt < 200) begin
            rready = toggle ? rr : 1'b1;
            if (rvalid && rready) begin
                e = sb.pop_front();
                check("rdata", rdata, e.d);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                check("rid", rid, id);
                step();
            end else if (rvalid) begin
                hold = {rdata, rresp, rlast};
                step();
                check("r_stable", {rdata, rresp, rlast}, hold);
            end else begin
                step();
            end
            rr = !rr;
            cnt++;
        end
        rready = 1'b0;
        check("r_beats_left", sb.size(), 0);
        sb.delete();
        check("r_no_extra", rvalid, 1'b0);
        check("arready_back", arready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_ready", {arready, awready, wready}, 3'b000);
        check("rst_valid", {rvalid, rlast, bvalid}, 3'b000);
        check("rst_rdata", rdata, 64'd0);
        check("rst_ids", {rid, bid, rresp, bresp}, 12'd0);
        aresetn = 1'b1;
        step();
        check("post_rst_ready", {arready, awready}, 2'b11);

        // INCR write then readback
        wdq = '{64'd1, 64'd2, 64'd3, 64'd4};
        do_write(32'h100, 8'd3, INCR, 4'h5, 4, 8'hFF, OKAY);
        push_exp(64'd1, OKAY, 1'b0); push_exp(64'd2, OKAY, 1'b0);
        push_exp(64'd3, OKAY, 1'b0); push_exp(64'd4, OKAY, 1'b1);
        do_read(32'h100, 8'd3, INCR, 4'h3, 1'b0);

        // WRAP: 0x118 -> 0x100 -> 0x108 -> 0x110
        push_exp(64'd4, OKAY, 1'b0); push_exp(64'd1, OKAY, 1'b0);
        push_exp(64'd2, OKAY, 1'b0); push_exp(64'd3, OKAY, 1'b1);
        do_read(32'h118, 8'd3, WRAP, 4'hA, 1'b0);

        // FIXED re-reads the same word
        push_exp(64'd2, OKAY, 1'b0); push_exp(64'd2, OKAY, 1'b1);
        do_read(32'h10C, 8'd1, FIXED, 4'h1, 1'b0);

        // 8-beat read under rready toggling
        wdq.delete();
        for (int i = 0; i < 8; i++) begin
            rnd[i] = {$urandom, $urandom};
            wdq.push_back(rnd[i]);
        end
        do_write(32'h200, 8'd7, INCR, 4'h2, 8, 8'hFF, OKAY);
        for (int i = 0; i < 8; i++) push_exp(rnd[i], OKAY, i == 7);
        do_read(32'h200, 8'd7, INCR, 4'h7, 1'b1);

        // Partial strobe
        wdq = '{64'hFFFF_FFFF_FFFF_FFFF};
        do_write(32'h300, 8'd0, INCR, 4'h1, 1, 8'hFF, OKAY);
        wdq = '{64'd0};
        do_write(32'h300, 8'd0, INCR, 4'h1, 1, 8'h0F, OKAY);
        push_exp(64'hFFFF_FFFF_0000_0000, OKAY, 1'b1);
        do_read(32'h300, 8'd0, INCR, 4'h4, 1'b0);

        // Out of range: address 0x8000 aliases word 0 if the range check were missing
        wdq = '{64'hA5A5_A5A5_A5A5_A5A5};
        do_write(32'h0, 8'd0, INCR, 4'h6, 1, 8'hFF, OKAY);
        push_exp(64'd0, SLVERR, 1'b1);
        do_read(32'h8000, 8'd0, INCR, 4'h6, 1'b0);
        wdq = '{64'h1234};
        do_write(32'h8000, 8'd0, INCR, 4'h6, 1, 8'hFF, SLVERR);
        push_exp(64'hA5A5_A5A5_A5A5_A5A5, OKAY, 1'b1);
        do_read(32'h0, 8'd0, INCR, 4'h6, 1'b0);

        // Illegal bursts behave as INCR with SLVERR on every beat
        push_exp(64'd1, SLVERR, 1'b0); push_exp(64'd2, SLVERR, 1'b1);
        do_read(32'h100, 8'd1, RSVD, 4'h8, 1'b0);
        push_exp(64'd1, SLVERR, 1'b0); push_exp(64'd2, SLVERR, 1'b0); push_exp(64'd3, SLVERR, 1'b1);
        do_read(32'h100, 8'd2, WRAP, 4'h9, 1'b0);

        // Early wlast: beats written so far land, response is SLVERR
        wdq = '{64'h11, 64'h22};
        do_write(32'h400, 8'd3, INCR, 4'hB, 2, 8'hFF, SLVERR);
        push_exp(64'h11, OKAY, 1'b0); push_exp(64'h22, OKAY, 1'b1);
        do_read(32'h400, 8'd1, INCR, 4'hB, 1'b0);

        // W data ahead of AW must wait
        wdata = 64'hCC; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_before_aw", wready, 1'b0);
        end
        wdq = '{64'hCC};
        do_write(32'h508, 8'd0, INCR, 4'hC, 1, 8'hFF, OKAY);

        // Overlong burst: beat past awlen is discarded
        wdq = '{64'hD1, 64'hD2};
        do_write(32'h500, 8'd0, INCR, 4'hD, 2, 8'hFF, SLVERR);
        push_exp(64'hD1, OKAY, 1'b0); push_exp(64'hCC, OKAY, 1'b1);
        do_read(32'h500, 8'd1, INCR, 4'hD, 1'b0);

        // Reset in the middle of an 8-beat read
        araddr = 32'h200; arlen = 8'd7; arburst = INCR; arid = 4'hE; arvalid = 1'b1;
        check("mid_ar_ready", arready, 1'b1);
        step();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mid_rdata", rdata, rnd[i]);
            step();
        end
        aresetn = 1'b0;
        #1;
        check("rst_rvalid_now", rvalid, 1'b0);
        check("rst_arready_now", arready, 1'b0);
        step();
        step();
        aresetn = 1'b1;
        check("arready_before_edge", arready, 1'b0);
        step();
        check("arready_after_rel", arready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("no_stale_beat", rvalid, 1'b0);
            step();
        end
        rready = 1'b0;

        // Memory survives reset
        push_exp(64'd1, OKAY, 1'b1);
        do_read(32'h100, 8'd0, INCR, 4'hF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
